spif_reg_bank_pn: RTL and testbench
===================================

Name: spif_reg_bank_pn

Overview:
Parametrised configuration/diagnostic register bank for the SPIF HSSL datapath, successor to the fixed-size HSSL register bank. It is accessed from two sides: an APB slave port, and an in-band packet port that supports both writes and reads, with read replies returned through a valid/ready reply channel. It holds HSSL control, input-router key/mask/route tables, mapper field mask/shift tables and saturating diagnostic counters. It sits between the APB interconnect, the packet receiver/transmitter, and the router/mapper.

Parameters:
NUM_HREGS, 4, HSSL control registers (reg 0 bit 0 = stop, reg 1 = mapper key)
NUM_RREGS, 16, router entries (key, mask, route)
NUM_CREGS, 4, diagnostic counters
NUM_MREGS, 4, mapper field entries (mask, shift)
ROUTE_W, 3, route field width
FSFT_W, 5, mapper shift field width
CTR_W, 32, counter width (1..32)
CTR_COR, 0, 1 = an APB read clears the counter it reads
ADDR_W, 40, APB address width

Ports:
clk  in  1  clock
resetn  in  1  reset, asynchronous, active-low
apb_psel_in  in  1  APB select
apb_penable_in  in  1  APB enable
apb_pwrite_in  in  1  APB write
apb_paddr_in  in  ADDR_W  byte address
apb_pwdata_in  in  32  write data
apb_prdata_out  out  32  read data
apb_pready_out  out  1  APB ready
apb_pslverr_out  out  1  APB error
prx_addr_in  in  8  packet word address
prx_data_in  in  32  packet write data
prx_wr_in  in  1  1 = write, 0 = read
prx_vld_in  in  1  request valid
prx_rdy_out  out  1  request ready
prt_addr_out  out  8  reply address (echoes the request)
prt_data_out  out  32  reply data
prt_vld_out  out  1  reply valid
prt_rdy_in  in  1  reply ready
ctr_cnt_in  in  NUM_CREGS  per-counter increment strobes
hssl_stop_out  out  1  HSSL reg 0 bit 0
mp_key_out  out  32  HSSL reg 1
reg_rt_key_out  out  NUM_RREGS*32  flattened, entry i at [32i+:32]
reg_rt_mask_out  out  NUM_RREGS*32  flattened
reg_rt_route_out  out  NUM_RREGS*ROUTE_W  flattened
reg_mp_fmsk_out  out  NUM_MREGS*32  flattened
reg_mp_fsft_out  out  NUM_MREGS*FSFT_W  flattened

Behaviour:
- Address decode, APB: section = paddr[8:6], index = paddr[5:2]. Packet: section = addr[6:4], index = addr[3:0].
- Section codes: H=0, K=1, M=2, R=3, C=4, A=5, S=6. Section 7 is invalid.
- Invalid access: section 7, or index >= the section's size.
  - Writes are dropped.
  - Reads return 32'hdead_beef.
  - APB additionally asserts pslverr together with pready.
- Counter section C is writable from both ports.
- Field widths: writes truncate to the field width; reads zero-extend to 32 bits.
- Reset: every register, counter, prdata, prt_data and prt_addr = 0. pready, pslverr, prx_rdy, prt_vld = 0.
- APB FSM, states A_IDLE, A_ACC, A_DONE:
  - A_IDLE -> A_ACC when psel && penable.
  - In A_ACC, the operation commits in the first cycle with no packet handshake (prx_vld && prx_rdy). A packet handshake defers the commit, and A_ACC holds.
  - On commit -> A_DONE. In A_DONE, pready = 1 for exactly one cycle, with prdata/pslverr valid; then -> A_IDLE.
  - Minimum access latency: 2 access-phase cycles.
  - psel dropping in A_ACC (protocol abort) -> A_IDLE, no commit.
- Packet FSM, states P_IDLE, P_REPLY:
  - prx_rdy = 1 only in P_IDLE, and never in the first cycle after reset.
  - Write handshake: the register updates on that clock edge; stay in P_IDLE.
  - Read handshake: prt_data/prt_addr are loaded on that edge -> P_REPLY. prt_vld holds until prt_rdy, then -> P_IDLE.
  - While in P_REPLY, prx_rdy = 0 (backpressure). The reply is stable while vld && !rdy.
- Priority: a packet write beats an APB write to the same cycle (the APB write is deferred, not lost). A packet read and an APB read never share a commit cycle.
- Counters:
  - Priority: packet write > APB write > APB read-clear (CTR_COR) > increment.
  - Saturate at all-ones; no wrap.
  - Clear plus increment in the same cycle yields 1.
  - Counter reads return the value before the clear.
- Outputs are combinational from the registers. A write is visible the cycle after commit.

Decomposition:
- Package spif_reg_pkg holds:
  - section codes;
  - APB/packet LSB constants;
  - the SEC_BITS=3 and IDX_BITS=4 constants;
  - DEAD_BEEF;
  - the apb_state_t and pkt_state_t enums.
- One sub-module, spif_sat_ctr: a CTR_W-bit saturating counter with inputs wr, wdata, clr, inc, generated NUM_CREGS times.

Test Plan:
- APB write 0xA5A5_0001 to K[3] (paddr 0x4C), then read it back -> pready high for one cycle, 2 access cycles each; prdata 0xA5A5_0001; reg_rt_key_out[127:96] = 0xA5A5_0001.
- APB access phase overlapping a packet write to H[0] = 1 -> APB pready delayed by one cycle; hssl_stop_out = 1; the APB write still lands.
- Packet read of R[2] (addr 0x32) after route = 5, with prt_rdy held low for 3 cycles -> prt_vld stable, prt_data = 5, prt_addr = 0x32; prx_rdy = 0 until the reply is accepted.
- CTR_W=4: pulse ctr_cnt_in[0] 20 times -> counter = 0xF, no wrap. With CTR_COR=1: APB read returns 0xF, the next read returns 0 (or 1 if a strobe coincided).
- APB read of A[NUM_MREGS] and of section 7 -> pslverr = 1, prdata 0xdead_beef. Packet write to S[7] with NUM_MREGS=4 -> no register changes.
- Assert resetn low mid-APB access and mid-reply -> all outputs return to 0 immediately. Post-reset, prx_rdy rises on the second cycle.

Source files
------------

// File: rtl/spif_reg_pkg.sv
// Shared constants and state types for the SPIF HSSL register bank.
package spif_reg_pkg;

  // Address field layout
  localparam int SEC_BITS    = 3;
  localparam int IDX_BITS    = 4;
  localparam int APB_IDX_LSB = 2;
  localparam int APB_SEC_LSB = 6;
  localparam int PKT_IDX_LSB = 0;
  localparam int PKT_SEC_LSB = 4;

  // Section codes (code 7 is never decoded as a valid section)
  localparam logic [SEC_BITS-1:0] SEC_H = 3'd0;  // HSSL control
  localparam logic [SEC_BITS-1:0] SEC_K = 3'd1;  // router key
  localparam logic [SEC_BITS-1:0] SEC_M = 3'd2;  // router mask
  localparam logic [SEC_BITS-1:0] SEC_R = 3'd3;  // router route
  localparam logic [SEC_BITS-1:0] SEC_C = 3'd4;  // diagnostic counters
  localparam logic [SEC_BITS-1:0] SEC_A = 3'd5;  // mapper field mask
  localparam logic [SEC_BITS-1:0] SEC_S = 3'd6;  // mapper field shift

  // Read value returned for any invalid location
  localparam logic [31:0] DEAD_BEEF = 32'hdead_beef;

  typedef enum logic [1:0] {
    A_IDLE = 2'd0,
    A_ACC  = 2'd1,
    A_DONE = 2'd2
  } apb_state_t;

  typedef enum logic {
    P_IDLE  = 1'b0,
    P_REPLY = 1'b1
  } pkt_state_t;

endpackage

// File: rtl/spif_sat_ctr.sv
// Saturating diagnostic counter: write > clear > increment, sticks at all-ones.
module spif_sat_ctr
  import spif_reg_pkg::*;
#(
  parameter int CTR_W = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             wr,
  input  logic [CTR_W-1:0] wdata,
  input  logic             clr,
  input  logic             inc,
  output logic [CTR_W-1:0] cnt
);

  localparam logic [CTR_W-1:0] CTR_MAX = {CTR_W{1'b1}};
  localparam logic [CTR_W-1:0] CTR_ONE = CTR_W'(1'b1);

  logic [CTR_W-1:0] r_cnt;

  // Counter update; a clear that coincides with a strobe leaves one count behind
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_cnt <= '0;
    end else if (wr) begin
      r_cnt <= wdata;
    end else if (clr) begin
      r_cnt <= inc ? CTR_ONE : '0;
    end else if (inc && (r_cnt != CTR_MAX)) begin
      r_cnt <= r_cnt + CTR_ONE;
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign cnt = r_cnt;

endmodule

// File: rtl/spif_reg_bank_pn.sv
// SPIF HSSL configuration/diagnostic register bank with an APB slave port
// and an in-band packet request/reply port.
module spif_reg_bank_pn
  import spif_reg_pkg::*;
#(
  parameter int NUM_HREGS = 4,
  parameter int NUM_RREGS = 16,
  parameter int NUM_CREGS = 4,
  parameter int NUM_MREGS = 4,
  parameter int ROUTE_W   = 3,
  parameter int FSFT_W    = 5,
  parameter int CTR_W     = 32,
  parameter int CTR_COR   = 0,
  parameter int ADDR_W    = 40
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         apb_psel_in,
  input  logic                         apb_penable_in,
  input  logic                         apb_pwrite_in,
  input  logic [ADDR_W-1:0]            apb_paddr_in,
  input  logic [31:0]                  apb_pwdata_in,
  output logic [31:0]                  apb_prdata_out,
  output logic                         apb_pready_out,
  output logic                         apb_pslverr_out,
  input  logic [7:0]                   prx_addr_in,
  input  logic [31:0]                  prx_data_in,
  input  logic                         prx_wr_in,
  input  logic                         prx_vld_in,
  output logic                         prx_rdy_out,
  output logic [7:0]                   prt_addr_out,
  output logic [31:0]                  prt_data_out,
  output logic                         prt_vld_out,
  input  logic                         prt_rdy_in,
  input  logic [NUM_CREGS-1:0]         ctr_cnt_in,
  output logic                         hssl_stop_out,
  output logic [31:0]                  mp_key_out,
  output logic [NUM_RREGS*32-1:0]      reg_rt_key_out,
  output logic [NUM_RREGS*32-1:0]      reg_rt_mask_out,
  output logic [NUM_RREGS*ROUTE_W-1:0] reg_rt_route_out,
  output logic [NUM_MREGS*32-1:0]      reg_mp_fmsk_out,
  output logic [NUM_MREGS*FSFT_W-1:0]  reg_mp_fsft_out
);

  // ---------------------------------------------------------------- state
  apb_state_t r_apb_state;
  pkt_state_t r_pkt_state;
  logic        r_pready;
  logic        r_pslverr;
  logic [31:0] r_prdata;
  logic        r_prx_rdy;
  logic        r_prt_vld;
  logic [31:0] r_prt_data;
  logic [7:0]  r_prt_addr;

  logic [31:0]        r_hreg     [NUM_HREGS];
  logic [31:0]        r_rt_key   [NUM_RREGS];
  logic [31:0]        r_rt_mask  [NUM_RREGS];
  logic [ROUTE_W-1:0] r_rt_route [NUM_RREGS];
  logic [31:0]        r_mp_fmsk  [NUM_MREGS];
  logic [FSFT_W-1:0]  r_mp_fsft  [NUM_MREGS];

  logic [NUM_CREGS*CTR_W-1:0] w_ctr_flat;
  logic [NUM_CREGS-1:0]       w_ctr_wr;
  logic [NUM_CREGS-1:0]       w_ctr_clr;

  // ---------------------------------------------------------------- decode
  logic [SEC_BITS-1:0] w_apb_sec, w_pkt_sec, w_wr_sec;
  logic [IDX_BITS-1:0] w_apb_idx, w_pkt_idx, w_wr_idx;
  logic                w_apb_ok, w_pkt_ok;
  logic                w_pkt_hs, w_pkt_wr, w_pkt_rd, w_apb_commit;
  logic                w_wr_en;
  logic [31:0]         w_wr_data;
  logic                w_unused;

  function automatic int sec_size(input logic [SEC_BITS-1:0] sec);
    int n;
    case (sec)
      SEC_H:               n = NUM_HREGS;
      SEC_K, SEC_M, SEC_R: n = NUM_RREGS;
      SEC_C:               n = NUM_CREGS;
      SEC_A, SEC_S:        n = NUM_MREGS;
      default:             n = 0;
    endcase
    return n;
  endfunction

  function automatic logic sec_valid(input logic [SEC_BITS-1:0] sec,
                                     input logic [IDX_BITS-1:0] idx);
    return (int'(idx) < sec_size(sec));
  endfunction

  // Read mux shared by both ports; narrow fields are zero-extended
  function automatic logic [31:0] rd_word(input logic [SEC_BITS-1:0] sec,
                                          input logic [IDX_BITS-1:0] idx);
    logic [31:0] v;
    v = DEAD_BEEF;
    if (sec_valid(sec, idx)) begin
      v = 32'h0000_0000;
      case (sec)
        SEC_H: for (int i = 0; i < NUM_HREGS; i++) if (int'(idx) == i) v = r_hreg[i];
        SEC_K: for (int i = 0; i < NUM_RREGS; i++) if (int'(idx) == i) v = r_rt_key[i];
        SEC_M: for (int i = 0; i < NUM_RREGS; i++) if (int'(idx) == i) v = r_rt_mask[i];
        SEC_R: for (int i = 0; i < NUM_RREGS; i++) if (int'(idx) == i) v[ROUTE_W-1:0] = r_rt_route[i];
        SEC_C: for (int i = 0; i < NUM_CREGS; i++) if (int'(idx) == i) v[CTR_W-1:0] = w_ctr_flat[i*CTR_W +: CTR_W];
        SEC_A: for (int i = 0; i < NUM_MREGS; i++) if (int'(idx) == i) v = r_mp_fmsk[i];
        SEC_S: for (int i = 0; i < NUM_MREGS; i++) if (int'(idx) == i) v[FSFT_W-1:0] = r_mp_fsft[i];
        default: v = DEAD_BEEF;
      endcase
    end
    return v;
  endfunction

  assign w_apb_sec = apb_paddr_in[APB_SEC_LSB +: SEC_BITS];
  assign w_apb_idx = apb_paddr_in[APB_IDX_LSB +: IDX_BITS];
  assign w_pkt_sec = prx_addr_in[PKT_SEC_LSB +: SEC_BITS];
  assign w_pkt_idx = prx_addr_in[PKT_IDX_LSB +: IDX_BITS];
  assign w_apb_ok  = sec_valid(w_apb_sec, w_apb_idx);
  assign w_pkt_ok  = sec_valid(w_pkt_sec, w_pkt_idx);
  assign w_unused  = ^{apb_paddr_in[ADDR_W-1:APB_SEC_LSB+SEC_BITS],
                       apb_paddr_in[APB_IDX_LSB-1:0], prx_addr_in[7]};

  // Any packet handshake owns the cycle, so the APB commit simply waits for a free one
  assign w_pkt_hs     = prx_vld_in & r_prx_rdy;
  assign w_pkt_wr     = w_pkt_hs & prx_wr_in;
  assign w_pkt_rd     = w_pkt_hs & ~prx_wr_in;
  assign w_apb_commit = (r_apb_state == A_ACC) & apb_psel_in & ~w_pkt_hs;

  // Single write port: at most one of packet write / APB write per cycle
  always_comb begin
    w_wr_en   = 1'b0;
    w_wr_sec  = '0;
    w_wr_idx  = '0;
    w_wr_data = 32'h0000_0000;
    if (w_pkt_wr) begin
      w_wr_en   = w_pkt_ok;
      w_wr_sec  = w_pkt_sec;
      w_wr_idx  = w_pkt_idx;
      w_wr_data = prx_data_in;
    end else if (w_apb_commit && apb_pwrite_in) begin
      w_wr_en   = w_apb_ok;
      w_wr_sec  = w_apb_sec;
      w_wr_idx  = w_apb_idx;
      w_wr_data = apb_pwdata_in;
    end else begin
      w_wr_en   = 1'b0;
    end
  end

  // Per-counter write and read-clear strobes
  always_comb begin
    w_ctr_wr  = '0;
    w_ctr_clr = '0;
    for (int i = 0; i < NUM_CREGS; i++) begin
      w_ctr_wr[i]  = w_wr_en && (w_wr_sec == SEC_C) && (int'(w_wr_idx) == i);
      w_ctr_clr[i] = (CTR_COR != 0) && w_apb_commit && !apb_pwrite_in && w_apb_ok &&
                     (w_apb_sec == SEC_C) && (int'(w_apb_idx) == i);
    end
  end

  // Configuration register storage, truncated to field width on write
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < NUM_HREGS; i++) r_hreg[i] <= '0;
      for (int i = 0; i < NUM_RREGS; i++) begin
        r_rt_key[i]   <= '0;
        r_rt_mask[i]  <= '0;
        r_rt_route[i] <= '0;
      end
      for (int i = 0; i < NUM_MREGS; i++) begin
        r_mp_fmsk[i] <= '0;
        r_mp_fsft[i] <= '0;
      end
    end else if (w_wr_en) begin
      case (w_wr_sec)
        SEC_H: for (int i = 0; i < NUM_HREGS; i++) if (int'(w_wr_idx) == i) r_hreg[i] <= w_wr_data;
        SEC_K: for (int i = 0; i < NUM_RREGS; i++) if (int'(w_wr_idx) == i) r_rt_key[i] <= w_wr_data;
        SEC_M: for (int i = 0; i < NUM_RREGS; i++) if (int'(w_wr_idx) == i) r_rt_mask[i] <= w_wr_data;
        SEC_R: for (int i = 0; i < NUM_RREGS; i++) if (int'(w_wr_idx) == i) r_rt_route[i] <= w_wr_data[ROUTE_W-1:0];
        SEC_A: for (int i = 0; i < NUM_MREGS; i++) if (int'(w_wr_idx) == i) r_mp_fmsk[i] <= w_wr_data;
        SEC_S: for (int i = 0; i < NUM_MREGS; i++) if (int'(w_wr_idx) == i) r_mp_fsft[i] <= w_wr_data[FSFT_W-1:0];
        default: ;
      endcase
    end
  end

  for (genvar g = 0; g < NUM_CREGS; g++) begin : g_ctr
    spif_sat_ctr #(
      .CTR_W (CTR_W)
    ) u_ctr (
      .clk    (clk),
      .resetn (resetn),
      .wr     (w_ctr_wr[g]),
      .wdata  (w_wr_data[CTR_W-1:0]),
      .clr    (w_ctr_clr[g]),
      .inc    (ctr_cnt_in[g]),
      .cnt    (w_ctr_flat[g*CTR_W +: CTR_W])
    );
  end

  // APB slave FSM; pready is a one-cycle pulse in A_DONE with prdata/pslverr
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_apb_state <= A_IDLE;
      r_pready    <= 1'b0;
      r_pslverr   <= 1'b0;
      r_prdata    <= 32'h0000_0000;
    end else begin
      case (r_apb_state)
        A_IDLE: begin
          r_pready  <= 1'b0;
          r_pslverr <= 1'b0;
          if (apb_psel_in && apb_penable_in) r_apb_state <= A_ACC;
        end
        A_ACC: begin
          if (!apb_psel_in) begin
            r_apb_state <= A_IDLE;
          end else if (w_pkt_hs) begin
            r_apb_state <= A_ACC;
          end else begin
            r_apb_state <= A_DONE;
            r_pready    <= 1'b1;
            r_pslverr   <= ~w_apb_ok;
            r_prdata    <= apb_pwrite_in ? 32'h0000_0000 : rd_word(w_apb_sec, w_apb_idx);
          end
        end
        A_DONE: begin
          r_apb_state <= A_IDLE;
          r_pready    <= 1'b0;
          r_pslverr   <= 1'b0;
        end
        default: begin
          r_apb_state <= A_IDLE;
          r_pready    <= 1'b0;
          r_pslverr   <= 1'b0;
        end
      endcase
    end
  end

  // Packet FSM; ready comes up one cycle after reset and drops while a reply is pending
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_pkt_state <= P_IDLE;
      r_prx_rdy   <= 1'b0;
      r_prt_vld   <= 1'b0;
      r_prt_data  <= 32'h0000_0000;
      r_prt_addr  <= 8'h00;
    end else begin
      case (r_pkt_state)
        P_IDLE: begin
          if (w_pkt_rd) begin
            r_pkt_state <= P_REPLY;
            r_prx_rdy   <= 1'b0;
            r_prt_vld   <= 1'b1;
            r_prt_data  <= rd_word(w_pkt_sec, w_pkt_idx);
            r_prt_addr  <= prx_addr_in;
          end else begin
            r_prx_rdy   <= 1'b1;
          end
        end
        P_REPLY: begin
          if (prt_rdy_in) begin
            r_pkt_state <= P_IDLE;
            r_prt_vld   <= 1'b0;
            r_prx_rdy   <= 1'b1;
          end
        end
        default: begin
          r_pkt_state <= P_IDLE;
          r_prt_vld   <= 1'b0;
          r_prx_rdy   <= 1'b0;
        end
      endcase
    end
  end

  // Flatten the table registers onto the router/mapper buses
  always_comb begin
    reg_rt_key_out   = '0;
    reg_rt_mask_out  = '0;
    reg_rt_route_out = '0;
    reg_mp_fmsk_out  = '0;
    reg_mp_fsft_out  = '0;
    for (int i = 0; i < NUM_RREGS; i++) begin
      reg_rt_key_out[32*i +: 32]             = r_rt_key[i];
      reg_rt_mask_out[32*i +: 32]            = r_rt_mask[i];
      reg_rt_route_out[ROUTE_W*i +: ROUTE_W] = r_rt_route[i];
    end
    for (int i = 0; i < NUM_MREGS; i++) begin
      reg_mp_fmsk_out[32*i +: 32]          = r_mp_fmsk[i];
      reg_mp_fsft_out[FSFT_W*i +: FSFT_W]  = r_mp_fsft[i];
    end
  end

  assign hssl_stop_out   = r_hreg[0][0];
  assign mp_key_out      = r_hreg[1];
  assign apb_prdata_out  = r_prdata;
  assign apb_pready_out  = r_pready;
  assign apb_pslverr_out = r_pslverr;
  assign prx_rdy_out     = r_prx_rdy;
  assign prt_vld_out     = r_prt_vld;
  assign prt_data_out    = r_prt_data;
  assign prt_addr_out    = r_prt_addr;

endmodule

// File: tb/tb_spif_reg_bank_pn.sv
// Directed self-checking bench for spif_reg_bank_pn (4-bit clear-on-read counters).
module tb_spif_reg_bank_pn;

  localparam int NR = 16;
  localparam int NM = 4;
  localparam int NC = 4;
  localparam int RW = 3;
  localparam int FW = 5;
  localparam int AW = 40;
  localparam logic [31:0] DB = 32'hdead_beef;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                resetn;
  logic                psel, penable, pwrite;
  logic [AW-1:0]       paddr;
  logic [31:0]         pwdata, prdata;
  logic                pready, pslverr;
  logic [7:0]          prx_addr, prt_addr;
  logic [31:0]         prx_data, prt_data;
  logic                prx_wr, prx_vld, prx_rdy, prt_vld, prt_rdy;
  logic [NC-1:0]       ctr_cnt;
  logic                hssl_stop;
  logic [31:0]         mp_key;
  logic [NR*32-1:0]    rt_key, rt_mask;
  logic [NR*RW-1:0]    rt_route;
  logic [NM*32-1:0]    mp_fmsk;
  logic [NM*FW-1:0]    mp_fsft;

  int errors = 0;
  int checks = 0;

  spif_reg_bank_pn #(
    .NUM_HREGS(4), .NUM_RREGS(NR), .NUM_CREGS(NC), .NUM_MREGS(NM),
    .ROUTE_W(RW), .FSFT_W(FW), .CTR_W(4), .CTR_COR(1), .ADDR_W(AW)
  ) dut (
    .clk(clk), .resetn(resetn),
    .apb_psel_in(psel), .apb_penable_in(penable), .apb_pwrite_in(pwrite),
    .apb_paddr_in(paddr), .apb_pwdata_in(pwdata), .apb_prdata_out(prdata),
    .apb_pready_out(pready), .apb_pslverr_out(pslverr),
    .prx_addr_in(prx_addr), .prx_data_in(prx_data), .prx_wr_in(prx_wr),
    .prx_vld_in(prx_vld), .prx_rdy_out(prx_rdy),
    .prt_addr_out(prt_addr), .prt_data_out(prt_data), .prt_vld_out(prt_vld),
    .prt_rdy_in(prt_rdy), .ctr_cnt_in(ctr_cnt),
    .hssl_stop_out(hssl_stop), .mp_key_out(mp_key),
    .reg_rt_key_out(rt_key), .reg_rt_mask_out(rt_mask), .reg_rt_route_out(rt_route),
    .reg_mp_fmsk_out(mp_fmsk), .reg_mp_fsft_out(mp_fsft)
  );

  // Full APB transfer; strb is held on ctr_cnt_in from setup until pready is seen
  task automatic apb_xfer(input logic [AW-1:0] addr, input logic wr, input logic [31:0] wdata,
                          input logic [NC-1:0] strb, output logic [31:0] rdata,
                          output logic slverr, output int waits);
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wdata; ctr_cnt = strb;
    @(negedge clk);
    penable = 1'b1;
    waits = 0;
    do begin
      @(negedge clk);
      waits++;
    end while (!pready && waits < 20);
    rdata = prdata;
    slverr = pslverr;
    checks++;
    if (pready !== 1'b1) begin
      errors++;
      $display("FAIL apb_timeout addr=%h pready=%b required 1", addr, pready);
    end
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0; ctr_cnt = '0;
    @(negedge clk);
    checks++;
    if (pready !== 1'b0) begin
      errors++;
      $display("FAIL apb_pready_pulse addr=%h pready=%b required 0", addr, pready);
    end
  endtask

  task automatic pkt_write(input logic [7:0] addr, input logic [31:0] data);
    int n;
    @(negedge clk);
    prx_addr = addr; prx_data = data; prx_wr = 1'b1; prx_vld = 1'b1;
    n = 0;
    while (!prx_rdy && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (prx_rdy !== 1'b1) begin
      errors++;
      $display("FAIL pkt_wr_timeout addr=%h prx_rdy=%b required 1", addr, prx_rdy);
    end
    @(negedge clk);
    prx_vld = 1'b0; prx_wr = 1'b0;
  endtask

  // Packet read with prt_rdy held low for 'hold' cycles before acceptance
  task automatic pkt_read(input logic [7:0] addr, input logic [31:0] exp_data, input int hold);
    int n;
    @(negedge clk);
    prx_addr = addr; prx_wr = 1'b0; prx_vld = 1'b1; prt_rdy = 1'b0;
    n = 0;
    while (!prx_rdy && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    prx_vld = 1'b0;
    checks++;
    if (prt_vld !== 1'b1 || prt_data !== exp_data || prt_addr !== addr) begin
      errors++;
      $display("FAIL pkt_rd_reply vld=%b data=%h addr=%h required 1 %h %h", prt_vld, prt_data, prt_addr, exp_data, addr);
    end
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      checks++;
      if (prt_vld !== 1'b1 || prt_data !== exp_data || prt_addr !== addr || prx_rdy !== 1'b0) begin
        errors++;
        $display("FAIL pkt_rd_hold cyc=%0d vld=%b data=%h addr=%h rdy=%b required 1 %h %h 0",
                 i, prt_vld, prt_data, prt_addr, prx_rdy, exp_data, addr);
      end
    end
    prt_rdy = 1'b1;
    @(negedge clk);
    prt_rdy = 1'b0;
    checks++;
    if (prt_vld !== 1'b0 || prx_rdy !== 1'b1) begin
      errors++;
      $display("FAIL pkt_rd_accept vld=%b rdy=%b required 0 1", prt_vld, prx_rdy);
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    checks++;
    if (pready !== 1'b0 || pslverr !== 1'b0 || prdata !== 32'h0 || prx_rdy !== 1'b0 ||
        prt_vld !== 1'b0 || prt_data !== 32'h0 || prt_addr !== 8'h00 || hssl_stop !== 1'b0 ||
        mp_key !== 32'h0 || rt_key !== '0 || rt_mask !== '0 || rt_route !== '0 ||
        mp_fmsk !== '0 || mp_fsft !== '0) begin
      errors++;
      $display("FAIL %s_zero pready=%b slverr=%b prdata=%h rdy=%b vld=%b pdata=%h paddr=%h stop=%b key=%h required all 0",
               tag, pready, pslverr, prdata, prx_rdy, prt_vld, prt_data, prt_addr, hssl_stop, mp_key);
    end
  endtask

  task automatic check_rdy_rise(input string tag);
    @(posedge clk);
    #1 resetn = 1'b1;
    @(negedge clk);
    checks++;
    if (prx_rdy !== 1'b0) begin
      errors++;
      $display("FAIL %s_rdy_first prx_rdy=%b required 0", tag, prx_rdy);
    end
    @(negedge clk);
    checks++;
    if (prx_rdy !== 1'b1) begin
      errors++;
      $display("FAIL %s_rdy_second prx_rdy=%b required 1", tag, prx_rdy);
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
    prx_addr = '0; prx_data = '0; prx_wr = 1'b0; prx_vld = 1'b0; prt_rdy = 1'b0; ctr_cnt = '0;
    repeat (3) @(negedge clk);
    check_zero_outputs("reset");
    check_rdy_rise("reset");
  endtask

  task automatic test_apb_rw();
    logic [31:0] rd;
    logic err;
    int w;
    apb_xfer(40'h4C, 1'b1, 32'hA5A5_0001, '0, rd, err, w);
    checks++;
    if (w !== 2 || err !== 1'b0 || rt_key[127:96] !== 32'hA5A5_0001) begin
      errors++;
      $display("FAIL apb_wr_k3 waits=%0d slverr=%b key3=%h required 2 0 a5a50001", w, err, rt_key[127:96]);
    end
    apb_xfer(40'h4C, 1'b0, 32'h0, '0, rd, err, w);
    checks++;
    if (w !== 2 || err !== 1'b0 || rd !== 32'hA5A5_0001) begin
      errors++;
      $display("FAIL apb_rd_k3 waits=%0d slverr=%b prdata=%h required 2 0 a5a50001", w, err, rd);
    end
    apb_xfer(40'h80, 1'b1, 32'hFFFF_0000, '0, rd, err, w);
    checks++;
    if (rt_mask[31:0] !== 32'hFFFF_0000 || rt_key[127:96] !== 32'hA5A5_0001) begin
      errors++;
      $display("FAIL apb_wr_m0 mask0=%h key3=%h required ffff0000 a5a50001", rt_mask[31:0], rt_key[127:96]);
    end
  endtask

  task automatic test_overlap();
    int w;
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 40'h04; pwdata = 32'h1234_5678;
    @(negedge clk);
    penable = 1'b1;
    @(negedge clk);
    w = 1;
    checks++;
    if (prx_rdy !== 1'b1) begin
      errors++;
      $display("FAIL ovl_pre_rdy prx_rdy=%b required 1", prx_rdy);
    end
    prx_addr = 8'h00; prx_data = 32'h0000_0001; prx_wr = 1'b1; prx_vld = 1'b1;
    @(negedge clk);
    w++;
    prx_vld = 1'b0; prx_wr = 1'b0;
    checks++;
    if (pready !== 1'b0 || hssl_stop !== 1'b1) begin
      errors++;
      $display("FAIL ovl_deferred pready=%b stop=%b required 0 1", pready, hssl_stop);
    end
    while (!pready && w < 20) begin
      @(negedge clk);
      w++;
    end
    checks++;
    if (w !== 3 || pslverr !== 1'b0) begin
      errors++;
      $display("FAIL ovl_latency waits=%0d slverr=%b required 3 0", w, pslverr);
    end
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    @(negedge clk);
    checks++;
    if (mp_key !== 32'h1234_5678 || hssl_stop !== 1'b1) begin
      errors++;
      $display("FAIL ovl_apb_landed mp_key=%h stop=%b required 12345678 1", mp_key, hssl_stop);
    end
  endtask

  task automatic test_pkt_read();
    logic [31:0] rd;
    logic err;
    int w;
    pkt_write(8'h32, 32'h0000_0005);
    pkt_write(8'h33, 32'h0000_00FF);
    checks++;
    if (rt_route[8:6] !== 3'd5 || rt_route[11:9] !== 3'd7) begin
      errors++;
      $display("FAIL pkt_wr_route r2=%0d r3=%0d required 5 7", rt_route[8:6], rt_route[11:9]);
    end
    pkt_read(8'h32, 32'h0000_0005, 3);
    apb_xfer(40'hCC, 1'b0, 32'h0, '0, rd, err, w);
    checks++;
    if (rd !== 32'h0000_0007 || err !== 1'b0) begin
      errors++;
      $display("FAIL apb_rd_r3 prdata=%h slverr=%b required 00000007 0", rd, err);
    end
  endtask

  task automatic test_counters();
    logic [31:0] rd;
    logic err;
    int w;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      ctr_cnt = 4'b0001;
    end
    @(negedge clk);
    ctr_cnt = 4'b0000;
    apb_xfer(40'h100, 1'b0, 32'h0, '0, rd, err, w);
    checks++;
    if (rd !== 32'h0000_000F || err !== 1'b0) begin
      errors++;
      $display("FAIL ctr0_sat prdata=%h slverr=%b required 0000000f 0", rd, err);
    end
    apb_xfer(40'h100, 1'b0, 32'h0, '0, rd, err, w);
    checks++;
    if (rd !== 32'h0000_0000) begin
      errors++;
      $display("FAIL ctr0_cleared prdata=%h required 00000000", rd);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      ctr_cnt = 4'b0010;
    end
    @(negedge clk);
    ctr_cnt = 4'b0000;
    apb_xfer(40'h104, 1'b0, 32'h0, 4'b0010, rd, err, w);
    checks++;
    if (rd !== 32'h0000_0005) begin
      errors++;
      $display("FAIL ctr1_pre_clear prdata=%h required 00000005", rd);
    end
    apb_xfer(40'h104, 1'b0, 32'h0, '0, rd, err, w);
    checks++;
    if (rd !== 32'h0000_0001) begin
      errors++;
      $display("FAIL ctr1_clr_inc prdata=%h required 00000001", rd);
    end
    pkt_write(8'h42, 32'hFFFF_FFF7);
    apb_xfer(40'h108, 1'b0, 32'h0, '0, rd, err, w);
    checks++;
    if (rd !== 32'h0000_0007) begin
      errors++;
      $display("FAIL ctr2_pkt_wr prdata=%h required 00000007", rd);
    end
  endtask

  task automatic test_invalid();
    logic [31:0] rd;
    logic err;
    int w;
    apb_xfer(40'h150, 1'b0, 32'h0, '0, rd, err, w);
    checks++;
    if (rd !== DB || err !== 1'b1) begin
      errors++;
      $display("FAIL inv_a4 prdata=%h slverr=%b required deadbeef 1", rd, err);
    end
    apb_xfer(40'h1C0, 1'b0, 32'h0, '0, rd, err, w);
    checks++;
    if (rd !== DB || err !== 1'b1) begin
      errors++;
      $display("FAIL inv_sec7 prdata=%h slverr=%b required deadbeef 1", rd, err);
    end
    apb_xfer(40'h150, 1'b1, 32'h1111_2222, '0, rd, err, w);
    checks++;
    if (err !== 1'b1 || mp_fmsk !== '0) begin
      errors++;
      $display("FAIL inv_wr_a4 slverr=%b fmsk=%h required 1 0", err, mp_fmsk);
    end
    pkt_write(8'h67, 32'h0000_001F);
    checks++;
    if (mp_fsft !== '0 || mp_fmsk !== '0) begin
      errors++;
      $display("FAIL inv_pkt_s7 fsft=%h fmsk=%h required 0 0", mp_fsft, mp_fmsk);
    end
    pkt_read(8'h70, DB, 1);
    pkt_write(8'h63, 32'h0000_00FF);
    checks++;
    if (mp_fsft !== 20'hF8000) begin
      errors++;
      $display("FAIL pkt_wr_s3 fsft=%h required f8000", mp_fsft);
    end
  endtask

  task automatic test_mid_reset();
    int n;
    pkt_write(8'h10, 32'h0000_CAFE);
    @(negedge clk);
    prx_addr = 8'h10; prx_wr = 1'b0; prx_vld = 1'b1; prt_rdy = 1'b0;
    @(negedge clk);
    prx_vld = 1'b0;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 40'h4C;
    checks++;
    if (prt_vld !== 1'b1 || prt_data !== 32'h0000_CAFE) begin
      errors++;
      $display("FAIL mid_reply vld=%b data=%h required 1 0000cafe", prt_vld, prt_data);
    end
    @(negedge clk);
    penable = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!pready && n < 20);
    checks++;
    if (pready !== 1'b1 || prdata !== 32'hA5A5_0001) begin
      errors++;
      $display("FAIL mid_apb pready=%b prdata=%h required 1 a5a50001", pready, prdata);
    end
    resetn = 1'b0;
    #1;
    check_zero_outputs("midrst");
    psel = 1'b0; penable = 1'b0;
    check_rdy_rise("midrst");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time=%0t required completion", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_apb_rw();
    test_overlap();
    test_pkt_read();
    test_counters();
    test_invalid();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
